// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM-style controller: FSM states, ALU
// control codes, instruction-field codes and datapath mux selects.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'b0100;
   localparam logic [3:0] ALU_SUB = 4'b0010;
   localparam logic [3:0] ALU_CMP = 4'b1010;

   localparam logic [1:0] OP_DP    = 2'b00;
   localparam logic [1:0] OP_MEM   = 2'b01;
   localparam logic [1:0] OP_BR    = 2'b10;
   localparam logic [1:0] OP_UNDEF = 2'b11;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] IMM_DP  = 2'b00;
   localparam logic [1:0] IMM_MEM = 2'b01;
   localparam logic [1:0] IMM_BR  = 2'b10;

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluator: cond field against stored {N,Z,C,V}.
// Only instantiated by multicycle_controller when COND_EXEC_EN is defined.
module cond_check
   import ctrl_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   logic n, z, c, v;
   assign {n, z, c, v} = flags;

   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_HI: pass = c && !z;
         COND_LS: pass = !c || z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = !z && (n == v);
         COND_LE: pass = z || (n != v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: FSM, datapath selects and NZCV register.
// Define COND_EXEC_EN to honour the cond field; otherwise everything runs as AL.
module multicycle_controller
   import ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W = 4
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [31:0]           INSTR,
   input  logic [3:0]            ALUFlags,
   output logic                  PCWrite,
   output logic                  IRWrite,
   output logic                  RegWrite,
   output logic                  MemWrite,
   output logic                  AdrSrc,
   output logic                  ALUSrcA,
   output logic [1:0]            ALUSrcB,
   output logic [1:0]            ResultSrc,
   output logic [1:0]            ImmSrc,
   output logic [1:0]            RegSrc,
   output logic [ALU_CTRL_W-1:0] ALUControl,
   output logic [3:0]            STATE,
   output logic [3:0]            FLAGS
);

   state_t     state, next_state, out_state;
   logic [3:0] flags;
   logic [1:0] op;
   logic [3:0] cmd;
   logic       imm_bit, s_bit, l_bit, u_bit, rd_pc;
   logic       cond_pass, flag_load;
   logic       unused_instr;

   assign op      = INSTR[27:26];
   assign imm_bit = INSTR[25];
   assign cmd     = INSTR[24:21];
   assign u_bit   = INSTR[23];
   assign s_bit   = INSTR[20];
   assign l_bit   = INSTR[20];
   assign rd_pc   = (INSTR[15:12] == 4'hF);

   assign unused_instr = ^{INSTR[31:28], INSTR[19:16], INSTR[11:0]};

`ifdef COND_EXEC_EN
   cond_check u_cond_check (
      .cond  (INSTR[31:28]),
      .flags (flags),
      .pass  (cond_pass)
   );
`else
   assign cond_pass = 1'b1;
`endif

   // CMP has no writeback, so it updates FLAGS even if S were clear.
   assign flag_load = (state == S_EXECR || state == S_EXECI) && (s_bit || cmd == ALU_CMP);

   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!RESET) begin
         state <= S_FETCH;
         flags <= 4'b0000;
      end else begin
         state <= next_state;
         if (flag_load) flags <= ALUFlags;
      end
   end

   always_comb begin
      // NOTE: default assigned first so no path through the case infers a latch.
      next_state = S_FETCH;
      case (state)
         S_FETCH:  next_state = S_DECODE;
         S_DECODE:
            if (cond_pass) begin
               case (op)
                  OP_DP:    next_state = imm_bit ? S_EXECI : S_EXECR;
                  OP_MEM:   next_state = S_MEMADR;
                  OP_BR:    next_state = S_BRANCH;
                  OP_UNDEF: next_state = S_FETCH;
               endcase
            end
         S_MEMADR: next_state = l_bit ? S_MEMRD : S_MEMWR;
         S_MEMRD:  next_state = S_MEMWB;
         S_EXECR,
         S_EXECI:  next_state = (cmd == ALU_CMP) ? S_FETCH : S_ALUWB;
         default:  next_state = S_FETCH;
      endcase
   end

   // Under reset the decoder shows FETCH, with the write enables masked below.
   assign out_state = RESET ? state : S_FETCH;
   assign STATE     = out_state;
   assign FLAGS     = flags;

   always_comb begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_RD2;
      ResultSrc  = RES_ALUOUT;
      ImmSrc     = IMM_DP;
      RegSrc     = 2'b00;
      ALUControl = '0;
      case (out_state)
         S_FETCH: begin
            IRWrite    = 1'b1;
            ALUSrcA    = 1'b1;
            ALUSrcB    = SRCB_FOUR;
            ALUControl = ALU_CTRL_W'(ALU_ADD);
            ResultSrc  = RES_ALU;
            PCWrite    = 1'b1;
         end
         S_DECODE: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = SRCB_FOUR;
            ALUControl = ALU_CTRL_W'(ALU_ADD);
         end
         S_EXECR, S_EXECI: begin
            ALUSrcB    = (out_state == S_EXECI) ? SRCB_IMM : SRCB_RD2;
            ImmSrc     = IMM_DP;
            ALUControl = ALU_CTRL_W'(cmd);
         end
         S_ALUWB: begin
            ResultSrc = RES_ALUOUT;
            RegWrite  = 1'b1;
            PCWrite   = rd_pc;
         end
         S_MEMADR: begin
            ALUSrcB    = SRCB_IMM;
            ImmSrc     = IMM_MEM;
            ALUControl = ALU_CTRL_W'(u_bit ? ALU_ADD : ALU_SUB);
         end
         S_MEMRD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = RES_RDATA;
            RegWrite  = 1'b1;
            PCWrite   = rd_pc;
         end
         S_MEMWR: begin
            AdrSrc   = 1'b1;
            RegSrc   = 2'b10;
            MemWrite = 1'b1;
         end
         S_BRANCH: begin
            RegSrc     = 2'b01;
            ALUSrcB    = SRCB_IMM;
            ImmSrc     = IMM_BR;
            ALUControl = ALU_CTRL_W'(ALU_ADD);
            ResultSrc  = RES_ALU;
            PCWrite    = 1'b1;
         end
         default: ;
      endcase
      if (!RESET) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level model expands each
// instruction into its expected per-cycle outputs; a negedge process compares.
module tb_multicycle_controller;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] INSTR;
   logic [3:0]  ALUFlags;
   logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
   logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc;
   logic [3:0]  ALUControl, STATE, FLAGS;

   multicycle_controller #(.ALU_CTRL_W(4)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .INSTR      (INSTR),
      .ALUFlags   (ALUFlags),
      .PCWrite    (PCWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .MemWrite   (MemWrite),
      .AdrSrc     (AdrSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ResultSrc  (ResultSrc),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .ALUControl (ALUControl),
      .STATE      (STATE),
      .FLAGS      (FLAGS)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, irw, rgw, mw, adr, srca;
      logic [1:0] srcb, res, imm, rsrc;
      logic [3:0] aluc, flg;
   } step_t;

   int         n_cmp  = 0;
   int         n_fail = 0;
   step_t      plan_q[$];
   step_t      exp_now;
   step_t      act_now;
   bit         exp_valid = 1'b0;
   logic [3:0] m_flags;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic step_t mk(input logic [3:0] st, input logic [3:0] f);
      step_t s;
      s     = '0;
      s.st  = st;
      s.flg = f;
      return s;
   endfunction

   function automatic step_t fetch_s(input logic [3:0] f);
      step_t s;
      s      = mk(4'd0, f);
      s.pcw  = 1'b1;
      s.irw  = 1'b1;
      s.srca = 1'b1;
      s.srcb = 2'b10;
      s.res  = 2'b10;
      s.aluc = 4'b0100;
      return s;
   endfunction

   function automatic step_t reset_s(input logic [3:0] f);
      step_t s;
      s     = fetch_s(f);
      s.pcw = 1'b0;
      s.irw = 1'b0;
      return s;
   endfunction

   function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v, r;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0:    r = z;
         3'd1:    r = cy;
         3'd2:    r = n;
         3'd3:    r = v;
         3'd4:    r = cy && !z;
         3'd5:    r = (n == v);
         3'd6:    r = !z && (n == v);
         default: r = 1'b1;
      endcase
      if (c == 4'b1111) return 1'b0;
      return c[0] ? !r : r;
   endfunction

   // Expands one instruction into the cycles it must take, updating m_flags.
   function automatic void build_plan(input logic [31:0] ins, input logic [3:0] af);
      step_t s;
      bit    pass;
      logic [1:0] op;
      logic [3:0] cmd;
      op  = ins[27:26];
      cmd = ins[24:21];
      plan_q.delete();
      plan_q.push_back(fetch_s(m_flags));
      s      = mk(4'd1, m_flags);
      s.srca = 1'b1;
      s.srcb = 2'b10;
      s.aluc = 4'b0100;
      plan_q.push_back(s);
`ifdef COND_EXEC_EN
      pass = cond_ok(ins[31:28], m_flags);
`else
      pass = 1'b1;
`endif
      if (!pass) return;
      if (op == 2'b00) begin
         s      = mk(ins[25] ? 4'd7 : 4'd6, m_flags);
         s.srcb = ins[25] ? 2'b01 : 2'b00;
         s.aluc = cmd;
         plan_q.push_back(s);
         if (ins[20] || cmd == 4'b1010) m_flags = af;
         if (cmd != 4'b1010) begin
            s     = mk(4'd8, m_flags);
            s.rgw = 1'b1;
            s.pcw = (ins[15:12] == 4'd15);
            plan_q.push_back(s);
         end
      end else if (op == 2'b01) begin
         s      = mk(4'd2, m_flags);
         s.srcb = 2'b01;
         s.imm  = 2'b01;
         s.aluc = ins[23] ? 4'b0100 : 4'b0010;
         plan_q.push_back(s);
         if (ins[20]) begin
            s     = mk(4'd3, m_flags);
            s.adr = 1'b1;
            plan_q.push_back(s);
            s     = mk(4'd4, m_flags);
            s.res = 2'b01;
            s.rgw = 1'b1;
            s.pcw = (ins[15:12] == 4'd15);
            plan_q.push_back(s);
         end else begin
            s      = mk(4'd5, m_flags);
            s.adr  = 1'b1;
            s.rsrc = 2'b10;
            s.mw   = 1'b1;
            plan_q.push_back(s);
         end
      end else if (op == 2'b10) begin
         s      = mk(4'd9, m_flags);
         s.rsrc = 2'b01;
         s.srcb = 2'b01;
         s.imm  = 2'b10;
         s.aluc = 4'b0100;
         s.res  = 2'b10;
         s.pcw  = 1'b1;
         plan_q.push_back(s);
      end
   endfunction

   always @(negedge CLK) begin
      if (exp_valid) begin
         act_now = {STATE, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                    ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, FLAGS};
         check($sformatf("cycle_state%0d", exp_now.st), {6'b0, act_now}, {6'b0, exp_now});
      end
   end

   task automatic run_instr(input string name, input logic [31:0] ins, input logic [3:0] af,
                            input int lat);
      INSTR    = ins;
      ALUFlags = af;
      build_plan(ins, af);
      check({name, "_latency"}, plan_q.size(), lat);
      foreach (plan_q[i]) begin
         exp_now   = plan_q[i];
         exp_valid = 1'b1;
         @(posedge CLK); #1;
      end
      exp_valid = 1'b0;
   endtask

   task automatic reset_mid_ldr();
      INSTR    = 32'hE590F004;
      ALUFlags = 4'b0000;
      build_plan(INSTR, ALUFlags);
      for (int i = 0; i < 3; i++) begin
         exp_now   = plan_q[i];
         exp_valid = 1'b1;
         @(posedge CLK); #1;
      end
      RESET   = 1'b0;
      exp_now = reset_s(m_flags);
      @(posedge CLK); #1;
      m_flags = 4'b0000;
      check("midrst_state", 32'(STATE), 32'd0);
      check("midrst_flags", 32'(FLAGS), 32'd0);
      check("midrst_we", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
      exp_now = reset_s(m_flags);
      @(posedge CLK); #1;
      exp_valid = 1'b0;
      RESET     = 1'b1;
      #1;
      check("release_irw_pcw", 32'({IRWrite, PCWrite}), 32'd3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat_beq_nt, lat_nv, lat_bne;
`ifdef COND_EXEC_EN
      lat_beq_nt = 2; lat_nv = 2; lat_bne = 2;
`else
      lat_beq_nt = 3; lat_nv = 4; lat_bne = 3;
`endif
      RESET    = 1'b0;
      INSTR    = 32'h0;
      ALUFlags = 4'b0000;
      m_flags  = 4'b0000;
      @(posedge CLK); #1;
      exp_now   = reset_s(4'b0000);
      exp_valid = 1'b1;
      @(posedge CLK); #1;
      exp_valid = 1'b0;
      check("rst_state", 32'(STATE), 32'd0);
      check("rst_flags", 32'(FLAGS), 32'd0);
      check("rst_we", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
      RESET = 1'b1;

      run_instr("subs", 32'hE0521003, 4'b0100, 4);
      check("subs_flags", 32'(FLAGS), 32'h4);
      run_instr("cmp_imm", 32'hE3510005, 4'b0010, 3);
      check("cmp_flags", 32'(FLAGS), 32'h2);
      run_instr("beq_z0", 32'h0A000002, 4'b0000, lat_beq_nt);
      run_instr("ldr_pc", 32'hE590F004, 4'b0000, 5);
      run_instr("str_neg", 32'hE5012008, 4'b0000, 4);
      run_instr("add_pc", 32'hE081F002, 4'b1111, 4);
      check("add_noS_flags", 32'(FLAGS), 32'h2);
      run_instr("undef", 32'hEC000000, 4'b0000, 2);
      run_instr("ands_imm", 32'hE2100001, 4'b1001, 4);
      check("ands_flags", 32'(FLAGS), 32'h9);
      run_instr("cmp_z", 32'hE3510005, 4'b0100, 3);
      run_instr("beq_z1", 32'h0A000002, 4'b0000, 3);
      run_instr("cond_nv", 32'hF0821003, 4'b0000, lat_nv);
      run_instr("bne_z1", 32'h1A000000, 4'b0000, lat_bne);
      reset_mid_ldr();
      run_instr("subs_after_rst", 32'hE0521003, 4'b1000, 4);
      check("final_flags", 32'(FLAGS), 32'h8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
